// File: rtl/trng_vn_packer.sv
`default_nettype none
// ============================================================================
// Module   : trng_vn_packer
// Brief    : Synchronises a raw TRNG bit, de-biases it with a von Neumann
//            corrector, packs the result into words and guards the source
//            with a repetition-count health test.
// Revision : 1.0
// ============================================================================
module trng_vn_packer #(
    parameter int SYNC_STAGES = 2,
    parameter int OUT_WIDTH   = 8,
    parameter int REP_LIMIT   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 raw_bit,
    input  logic                 sample_en,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 health_fail,
    output logic                 overrun
);

    localparam int CW = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
    localparam int RW = $clog2(REP_LIMIT + 1);

    localparam logic [CW-1:0] c_cnt_last  = CW'(OUT_WIDTH - 1);
    localparam logic [CW-1:0] c_cnt_one   = CW'(1);
    localparam logic [RW-1:0] c_rep_limit = RW'(REP_LIMIT);
    localparam logic [RW-1:0] c_rep_one   = RW'(1);

    typedef enum logic [0:0] {
        ST_FIRST  = 1'b0,
        ST_SECOND = 1'b1
    } pair_state_t;

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], raw_bit};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Repetition-count health test
    // ------------------------------------------------------------------
    logic [RW-1:0] r_rep_cnt;
    logic          r_last;
    logic          r_health_fail;
    logic [RW-1:0] w_rep_next;
    logic          w_trip;

    // A zero count means no sample has been seen yet, so the first sample
    // always starts a fresh run regardless of the reset value of r_last.
    always_comb begin
        w_rep_next = c_rep_one;
        if ((r_rep_cnt != '0) && (w_s == r_last)) begin
            w_rep_next = (r_rep_cnt == c_rep_limit) ? c_rep_limit
                                                    : r_rep_cnt + c_rep_one;
        end
    end

    assign w_trip = sample_en && (w_rep_next == c_rep_limit);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep_cnt     <= '0;
            r_last        <= 1'b0;
            r_health_fail <= 1'b0;
        end else if (sample_en) begin
            r_rep_cnt <= w_rep_next;
            r_last    <= w_s;
            if (w_trip) begin
                r_health_fail <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pair FSM, packer and single-entry output buffer
    // ------------------------------------------------------------------
    pair_state_t            r_state;
    logic                   r_a;
    logic [OUT_WIDTH-2:0]   r_sh;
    logic [CW-1:0]          r_cnt;
    logic [OUT_WIDTH-1:0]   r_out_data;
    logic                   r_out_valid;
    logic                   r_overrun;

    logic                   w_pair_go;
    logic                   w_emit;
    logic                   w_word_done;
    logic                   w_drain;
    logic [OUT_WIDTH-1:0]   w_sh_next;

    // The tripping sample itself is already suppressed, not only later ones.
    assign w_pair_go   = sample_en && !r_health_fail && !w_trip;
    assign w_emit      = w_pair_go && (r_state == ST_SECOND) && (r_a != w_s);
    assign w_word_done = w_emit && (r_cnt == c_cnt_last);
    assign w_drain     = r_out_valid && out_ready;
    assign w_sh_next   = {r_sh, r_a};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_FIRST;
            r_a         <= 1'b0;
            r_sh        <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_pair_go) begin
                case (r_state)
                    ST_FIRST: begin
                        r_a     <= w_s;
                        r_state <= ST_SECOND;
                    end
                    default: begin
                        r_state <= ST_FIRST;
                    end
                endcase
            end

            if (w_emit) begin
                r_sh  <= w_sh_next[OUT_WIDTH-2:0];
                r_cnt <= w_word_done ? '0 : r_cnt + c_cnt_one;
            end

            if (w_word_done) begin
                if (!r_out_valid || w_drain) begin
                    r_out_data  <= w_sh_next;
                    r_out_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign health_fail = r_health_fail;
    assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_trng_vn_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_trng_vn_packer
// Brief    : Directed and randomised bench for trng_vn_packer with a
//            queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_trng_vn_packer;

    localparam int SYNC_STAGES = 2;
    localparam int OUT_WIDTH   = 8;
    localparam int REP_LIMIT   = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 raw_bit;
    logic                 sample_en;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 health_fail;
    logic                 overrun;

    trng_vn_packer #(
        .SYNC_STAGES (SYNC_STAGES),
        .OUT_WIDTH   (OUT_WIDTH),
        .REP_LIMIT   (REP_LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .raw_bit     (raw_bit),
        .sample_en   (sample_en),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .health_fail (health_fail),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: sample pipeline, pending pair, collected bits.
    bit                   mq_sync[$];
    bit                   m_pend[$];
    bit                   m_bits[$];
    logic [OUT_WIDTH-1:0] m_data;
    bit                   m_valid;
    bit                   m_overrun;
    bit                   m_fail;
    int                   m_run;
    bit                   m_last;
    bit                   m_have;

    int                   hs_count;
    logic [OUT_WIDTH-1:0] hs_word;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit raw, input bit en, input bit rdy);
        bit                   s;
        bit                   drain;
        bit                   done;
        logic [OUT_WIDTH-1:0] w;
        if (r) begin
            mq_sync = {};
            for (int i = 0; i < SYNC_STAGES; i++) mq_sync.push_back(1'b0);
            m_pend = {};
            m_bits = {};
            m_data = '0;
            m_valid = 0; m_overrun = 0; m_fail = 0;
            m_run = 0; m_last = 0; m_have = 0;
            return;
        end
        mq_sync.push_back(raw);
        s = mq_sync.pop_front();
        drain = m_valid && rdy;
        done = 0;
        w = '0;
        if (en) begin
            if (m_have && s == m_last) m_run = (m_run < REP_LIMIT) ? m_run + 1 : REP_LIMIT;
            else                       m_run = 1;
            m_last = s;
            m_have = 1;
            if (!m_fail && m_run != REP_LIMIT) begin
                m_pend.push_back(s);
                if (m_pend.size() == 2) begin
                    if (m_pend[0] != m_pend[1]) m_bits.push_back(m_pend[0]);
                    m_pend = {};
                end
                if (m_bits.size() == OUT_WIDTH) begin
                    foreach (m_bits[i]) w = {w[OUT_WIDTH-2:0], m_bits[i]};
                    m_bits = {};
                    done = 1;
                end
            end
            if (m_run == REP_LIMIT) m_fail = 1;
        end
        if (done) begin
            if (!m_valid || drain) begin
                m_data  = w;
                m_valid = 1;
            end else begin
                m_overrun = 1;
            end
        end else if (drain) begin
            m_valid = 0;
        end
    endtask

    task automatic cycle(input bit r, input bit raw, input bit en, input bit rdy);
        rst = r; raw_bit = raw; sample_en = en; out_ready = rdy;
        if (!r && out_valid === 1'b1 && rdy) begin
            hs_count++;
            hs_word = out_data;
        end
        model_edge(r, raw, en, rdy);
        @(posedge clk);
        #1;
        check("out_data",    32'(out_data),    32'(m_data));
        check("out_valid",   32'(out_valid),   32'(m_valid));
        check("overrun",     32'(overrun),     32'(m_overrun));
        check("health_fail", 32'(health_fail), 32'(m_fail));
    endtask

    task automatic samp(input bit v, input bit rdy);
        for (int i = 0; i < SYNC_STAGES; i++) cycle(0, v, 0, rdy);
        cycle(0, v, 1, rdy);
    endtask

    task automatic pair_bit(input bit b, input bit rdy);
        samp(b, rdy);
        samp(~b, rdy);
    endtask

    task automatic send_word(input logic [OUT_WIDTH-1:0] w, input bit rdy, input bit junk);
        for (int i = OUT_WIDTH - 1; i >= 0; i--) begin
            if (junk) begin
                samp(i[0], rdy);
                samp(i[0], rdy);
            end
            pair_bit(w[i], rdy);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1, i[0], 1, 1);
    endtask

    initial begin
        // Reset with the raw bit toggling
        do_reset(2);
        check("rst_data",   32'(out_data),    32'h0);
        check("rst_valid",  32'(out_valid),   32'h0);
        check("rst_health", 32'(health_fail), 32'h0);
        check("rst_ovr",    32'(overrun),     32'h0);
        for (int i = 0; i < 4; i++) cycle(0, i[0], 0, 1);
        check("idle_valid", 32'(out_valid), 32'h0);

        // Packing
        hs_count = 0;
        send_word(8'hA5, 1, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        check("pack_count", 32'(hs_count), 32'd1);
        check("pack_word",  32'(hs_word),  32'hA5);

        // Discarded equal pairs interleaved
        do_reset(1);
        hs_count = 0;
        send_word(8'hA5, 1, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
        check("disc_count", 32'(hs_count), 32'd1);
        check("disc_word",  32'(hs_word),  32'hA5);

        // Backpressure and overrun
        do_reset(1);
        hs_count = 0;
        send_word(8'hA5, 0, 0);
        send_word(8'h3C, 0, 0);
        check("bp_data",  32'(out_data), 32'hA5);
        check("bp_ovr",   32'(overrun),  32'h1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("bp_count", 32'(hs_count),  32'd1);
        check("bp_valid", 32'(out_valid), 32'h0);

        // Health test with a buffered word and a partial word in flight
        do_reset(1);
        hs_count = 0;
        send_word(8'hA5, 0, 0);
        pair_bit(1, 0); pair_bit(0, 0); pair_bit(1, 0);
        for (int i = 0; i < REP_LIMIT - 1; i++) samp(1, 0);
        check("hl_before", 32'(health_fail), 32'h0);
        samp(1, 0);
        check("hl_trip", 32'(health_fail), 32'h1);
        for (int i = 0; i < 2 * OUT_WIDTH; i++) pair_bit(i[0], 0);
        check("hl_frozen_data", 32'(out_data), 32'hA5);
        check("hl_frozen_ovr",  32'(overrun),  32'h0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        check("hl_drain_cnt",  32'(hs_count),  32'd1);
        check("hl_drain_word", 32'(hs_word),   32'hA5);
        check("hl_drain_vld",  32'(out_valid), 32'h0);
        do_reset(1);
        check("hl_rst", 32'(health_fail), 32'h0);

        // Reset mid-word and mid-pair
        pair_bit(1, 1); pair_bit(1, 1); pair_bit(0, 1); pair_bit(0, 1); pair_bit(1, 1);
        samp(1, 1);
        do_reset(2);
        hs_count = 0;
        send_word(8'h3C, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
        check("mid_count", 32'(hs_count), 32'd1);
        check("mid_word",  32'(hs_word),  32'h3C);

        // Randomised traffic, including stuck-source stretches and resets
        for (int i = 0; i < 6000; i++) begin
            bit r, raw, en, rdy;
            r   = ($urandom_range(0, 399) == 0);
            raw = ((i % 1500) > 1380) ? 1'b1 : 1'($urandom);
            en  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 4) != 0);
            cycle(r, raw, en, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
